scroller_param: RTL and testbench

Parametrised address sequencer that steps through a DEPTH-entry RAM of per-hour car counts. Each address is held for DWELL clock cycles. It adds a start command, an enable/pause input, up/down direction, free-run vs one-shot mode, and valid/wrap/done status outputs. It drives the read-address port of the hourly-count RAM and the display path.

---
 rtl/scroller_param_if.sv | 51 +++++
 rtl/scroller_param.sv | 163 ++++++++++++++++
 tb/tb_scroller_param.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/scroller_param_if.sv
`default_nettype none
// ============================================================================
// Module      : scroller_param_if
// Description : Command / status bundle between a scan controller and the
//               scroller_param address sequencer.
//               master modport : scan controller (drives commands)
//               slave modport  : sequencer (drives address and status)
// Signals     : start, en, dir, oneshot        command inputs to sequencer
//               addr[ADDR_W], addr_valid,      registered sequencer outputs
//               wrap, done
//               load, load_addr[ADDR_W]        present only with SCROLL_LOAD_EN
// Config      : SCROLL_LOAD_EN adds the direct address-load command pair.
// Revision    : 1.0 - initial release
// ============================================================================
interface scroller_param_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic              en;
  logic              dir;
  logic              oneshot;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              wrap;
  logic              done;
`ifdef SCROLL_LOAD_EN
  logic              load;
  logic [ADDR_W-1:0] load_addr;
`endif

`ifdef SCROLL_LOAD_EN
  modport master (
    output start, en, dir, oneshot, load, load_addr,
    input  addr, addr_valid, wrap, done
  );
  modport slave (
    input  start, en, dir, oneshot, load, load_addr,
    output addr, addr_valid, wrap, done
  );
`else
  modport master (
    output start, en, dir, oneshot,
    input  addr, addr_valid, wrap, done
  );
  modport slave (
    input  start, en, dir, oneshot,
    output addr, addr_valid, wrap, done
  );
`endif
endinterface
`default_nettype wire

// File: rtl/scroller_param.sv
`default_nettype none
// ============================================================================
// Module      : scroller_param
// Description : Address sequencer for the hourly car-count RAM. Walks the
//               addresses 0..DEPTH-1 up or down, holding each for DWELL
//               enabled cycles, in free-running or one-shot mode.
// Ports       : clk          system clock, rising edge
//               rst          asynchronous reset, active low
//               bus (slave)  start/en/dir/oneshot in;
//                            addr/addr_valid/wrap/done out (all registered)
// Parameters  : DEPTH  (1..2**ADDR_W) number of scanned addresses
//               ADDR_W width of addr
//               DWELL  (>=1) cycles each address is held
// Config      : SCROLL_LOAD_EN enables bus.load / bus.load_addr, which jump
//               the scan to a (clamped) address while scanning.
// Revision    : 1.0 - initial release
// ============================================================================
module scroller_param #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 4,
  parameter int DWELL  = 1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  scroller_param_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                DW_W         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]   c_DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [ADDR_W-1:0] c_ADDR_MAX   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_ADDR_ZERO  = '0;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_SCAN = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DW_W-1:0]   r_dwell;
  logic              r_addr_valid;
  logic              r_wrap;
  logic              r_done;

  // --------------------------------------------------------------------------
  // Next-state wires
  // --------------------------------------------------------------------------
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DW_W-1:0]   w_dwell_nxt;
  logic              w_valid_nxt;
  logic              w_wrap_nxt;
  logic              w_done_nxt;

  logic [ADDR_W-1:0] w_first;
  logic [ADDR_W-1:0] w_last;
  logic [ADDR_W-1:0] w_step;
  logic              w_at_last;
  logic              w_dwell_end;
  logic              w_load;
  logic [ADDR_W-1:0] w_load_addr;

  // First/last address follow dir as sampled on the current edge, so a
  // direction change mid-scan simply reverses from wherever addr is.
  assign w_first     = bus.dir ? c_ADDR_MAX  : c_ADDR_ZERO;
  assign w_last      = bus.dir ? c_ADDR_ZERO : c_ADDR_MAX;
  assign w_at_last   = (r_addr == w_last);
  assign w_dwell_end = (r_dwell == c_DWELL_LAST);

  // The step is only used when addr is not the last address, so addr-1 never
  // underflows below 0 and addr+1 never passes DEPTH-1.
  assign w_step = bus.dir ? (r_addr - ADDR_W'(1)) : (r_addr + ADDR_W'(1));

`ifdef SCROLL_LOAD_EN
  assign w_load      = bus.load;
  // Out-of-range load targets saturate to the highest legal address.
  assign w_load_addr = (bus.load_addr > c_ADDR_MAX) ? c_ADDR_MAX : bus.load_addr;
`else
  assign w_load      = 1'b0;
  assign w_load_addr = c_ADDR_ZERO;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic. Priority: start > load > advance.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_dwell_nxt = r_dwell;
    w_valid_nxt = r_addr_valid;
    w_wrap_nxt  = 1'b0;
    w_done_nxt  = r_done;

    if (bus.start) begin
      // Start/restart from any state; suppresses any wrap on this edge.
      w_state_nxt = c_ST_SCAN;
      w_addr_nxt  = w_first;
      w_dwell_nxt = '0;
      w_valid_nxt = 1'b1;
      w_done_nxt  = 1'b0;
    end else if (r_state == c_ST_SCAN) begin
      if (w_load) begin
        w_addr_nxt  = w_load_addr;
        w_dwell_nxt = '0;
      end else if (bus.en) begin
        if (!w_dwell_end) begin
          w_dwell_nxt = r_dwell + DW_W'(1);
        end else begin
          w_dwell_nxt = '0;
          if (!w_at_last) begin
            w_addr_nxt = w_step;
          end else begin
            w_wrap_nxt = 1'b1;
            if (bus.oneshot) begin
              // Park on the last address with status flipped to done.
              w_state_nxt = c_ST_DONE;
              w_valid_nxt = 1'b0;
              w_done_nxt  = 1'b1;
            end else begin
              w_addr_nxt = w_first;
            end
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= c_ST_IDLE;
      r_addr       <= '0;
      r_dwell      <= '0;
      r_addr_valid <= 1'b0;
      r_wrap       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_dwell      <= w_dwell_nxt;
      r_addr_valid <= w_valid_nxt;
      r_wrap       <= w_wrap_nxt;
      r_done       <= w_done_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.addr       = r_addr;
  assign bus.addr_valid = r_addr_valid;
  assign bus.wrap       = r_wrap;
  assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_scroller_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_scroller_param
// Description : Self-checking bench for scroller_param. Two instances
//               (DWELL=1 and DWELL=3, DEPTH=8) share clock, reset and
//               commands. A behavioural model pushes expected outputs into a
//               per-instance queue each cycle; they are popped and compared
//               one time unit after the clock edge. Directed checks cover the
//               asynchronous reset and named scan milestones.
// Config      : SCROLL_LOAD_EN exercises the load command.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scroller_param;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 4;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] addr;
    logic [7:0] dw;
    logic       valid;
    logic       wrap;
    logic       done;
  } mdl_t;

  logic clk;
  logic rst;
  logic start, en, dir, oneshot;
  logic load;
  logic [ADDR_W-1:0] load_addr;

  int n_cmp;
  int n_err;

  mdl_t m1, m3;
  logic [6:0] q1[$];
  logic [6:0] q3[$];

  scroller_param_if #(.ADDR_W(ADDR_W)) bus1 ();
  scroller_param_if #(.ADDR_W(ADDR_W)) bus3 ();

  assign bus1.start = start;   assign bus3.start = start;
  assign bus1.en = en;         assign bus3.en = en;
  assign bus1.dir = dir;       assign bus3.dir = dir;
  assign bus1.oneshot = oneshot; assign bus3.oneshot = oneshot;
`ifdef SCROLL_LOAD_EN
  assign bus1.load = load;     assign bus3.load = load;
  assign bus1.load_addr = load_addr; assign bus3.load_addr = load_addr;
`endif

  scroller_param #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DWELL(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  scroller_param #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DWELL(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model of one edge (states: 0 idle, 1 scan, 2 done).
  function automatic mdl_t mdl_next(input mdl_t m, input int dwell,
                                    input logic s, input logic e,
                                    input logic d, input logic os,
                                    input logic ld, input int ld_addr);
    mdl_t n;
    int first;
    int last;
    n      = m;
    n.wrap = 1'b0;
    first  = d ? DEPTH - 1 : 0;
    last   = d ? 0 : DEPTH - 1;
    if (s) begin
      n.st = 2'd1; n.addr = 4'(first); n.dw = '0; n.valid = 1'b1; n.done = 1'b0;
    end else if (m.st == 2'd1) begin
      if (ld) begin
        n.addr = (ld_addr > DEPTH - 1) ? 4'(DEPTH - 1) : 4'(ld_addr);
        n.dw   = '0;
      end else if (e) begin
        if (int'(m.dw) < dwell - 1) begin
          n.dw = m.dw + 8'd1;
        end else begin
          n.dw = '0;
          if (int'(m.addr) == last) begin
            n.wrap = 1'b1;
            if (os) begin
              n.st = 2'd2; n.valid = 1'b0; n.done = 1'b1;
            end else begin
              n.addr = 4'(first);
            end
          end else begin
            n.addr = d ? m.addr - 4'd1 : m.addr + 4'd1;
          end
        end
      end
    end
    return n;
  endfunction

  // One clock: predict, enqueue, advance, pop and compare.
  task automatic cycle();
    mdl_t n1, n3;
    logic [6:0] e1, e3;
    logic ld;
    ld = 1'b0;
`ifdef SCROLL_LOAD_EN
    ld = load;
`endif
    if (rst) begin
      n1 = mdl_next(m1, 1, start, en, dir, oneshot, ld, int'(load_addr));
      n3 = mdl_next(m3, 3, start, en, dir, oneshot, ld, int'(load_addr));
    end else begin
      n1 = '0;
      n3 = '0;
    end
    q1.push_back({n1.addr, n1.valid, n1.wrap, n1.done});
    q3.push_back({n3.addr, n3.valid, n3.wrap, n3.done});
    m1 = n1;
    m3 = n3;
    @(posedge clk);
    #1;
    e1 = q1.pop_front();
    e3 = q3.pop_front();
    check("d1.addr",  int'(bus1.addr),       int'(e1[6:3]));
    check("d1.valid", int'(bus1.addr_valid), int'(e1[2]));
    check("d1.wrap",  int'(bus1.wrap),       int'(e1[1]));
    check("d1.done",  int'(bus1.done),       int'(e1[0]));
    check("d3.addr",  int'(bus3.addr),       int'(e3[6:3]));
    check("d3.valid", int'(bus3.addr_valid), int'(e3[2]));
    check("d3.wrap",  int'(bus3.wrap),       int'(e3[1]));
    check("d3.done",  int'(bus3.done),       int'(e3[0]));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    int wraps;
    n_cmp = 0; n_err = 0;
    m1 = '0; m3 = '0;
    rst = 1'b0; start = 1'b0; en = 1'b0; dir = 1'b0; oneshot = 1'b0;
    load = 1'b0; load_addr = '0;

    // Reset state
    repeat (3) cycle();
    check("rst.addr",  int'(bus1.addr), 0);
    check("rst.valid", int'(bus3.addr_valid), 0);
    rst = 1'b1;
    cycle();

    // 1: DWELL=1 free-running upward scan with wrap
    en = 1'b1; dir = 1'b0; oneshot = 1'b0;
    pulse_start();
    check("t1.first", int'(bus1.addr), 0);
    wraps = 0;
    for (int k = 0; k < 16; k++) begin
      cycle();
      if (bus1.wrap) wraps++;
    end
    check("t1.wraps", wraps, 2);

    // 2: downward one-shot, DWELL=3 instance runs to done and parks
    dir = 1'b1; oneshot = 1'b1;
    pulse_start();
    check("t2.first", int'(bus3.addr), 7);
    repeat (8 * 3 + 15) cycle();
    check("t2.done",  int'(bus3.done), 1);
    check("t2.valid", int'(bus3.addr_valid), 0);
    check("t2.addr",  int'(bus3.addr), 0);

    // 3: pause with en=0 at addr 3 of the DWELL=3 instance
    dir = 1'b0; oneshot = 1'b0;
    pulse_start();
    for (int k = 0; k < 40 && bus3.addr != 4'd3; k++) cycle();
    check("t3.reach3", int'(bus3.addr), 3);
    cycle();
    en = 1'b0;
    repeat (5) cycle();
    check("t3.frozen", int'(bus3.addr), 3);
    en = 1'b1;
    repeat (5) cycle();

    // 4: reverse direction at addr 5 of the DWELL=1 instance
    pulse_start();
    for (int k = 0; k < 20 && bus1.addr != 4'd5; k++) cycle();
    check("t4.reach5", int'(bus1.addr), 5);
    dir = 1'b1;
    cycle();
    check("t4.rev4", int'(bus1.addr), 4);
    repeat (3) cycle();

    // 5a: start on the same edge as the 7->0 wrap
    dir = 1'b0;
    pulse_start();
    for (int k = 0; k < 20 && bus1.addr != 4'd7; k++) cycle();
    check("t5.reach7", int'(bus1.addr), 7);
    pulse_start();
    check("t5.nowrap", int'(bus1.wrap), 0);
    repeat (2) cycle();

    // 5b: asynchronous reset mid-scan, checked between clock edges
    pulse_start();
    for (int k = 0; k < 20 && bus1.addr != 4'd4; k++) cycle();
    check("t5.reach4", int'(bus1.addr), 4);
    #2;
    rst = 1'b0;
    #1;
    check("t5.arst.addr",  int'(bus1.addr), 0);
    check("t5.arst.valid", int'(bus1.addr_valid), 0);
    cycle();
    rst = 1'b1;
    cycle();

`ifdef SCROLL_LOAD_EN
    // 6: load during scan, including a clamped out-of-range target
    pulse_start();
    repeat (3) cycle();
    load = 1'b1; load_addr = 4'd2;
    cycle();
    load = 1'b0;
    check("t6.load2", int'(bus1.addr), 2);
    repeat (2) cycle();
    load = 1'b1; load_addr = 4'd12;
    cycle();
    load = 1'b0;
    check("t6.clamp", int'(bus3.addr), 7);
    repeat (4) cycle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
